csr_reg: RTL and testbench

CSR_REG -- requirements
Module: csr_reg

---
 rtl/csr_reg.sv | 159 +++++++++++++++
 tb/tb_csr_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_reg.sv
// rtl/csr_reg.sv - machine-mode CSR file with execute and interrupt-controller ports
module csr_reg #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_csr_we_i,
   input  logic [11:0]     ex_csr_waddr_i,
   input  logic [XLEN-1:0] ex_csr_wdata_i,
   input  logic [11:0]     ex_csr_raddr_i,
   output logic [XLEN-1:0] ex_csr_rdata_o,
   input  logic            clint_we_i,
   input  logic [11:0]     clint_addr_i,
   input  logic [XLEN-1:0] clint_wdata_i,
   output logic [XLEN-1:0] clint_rdata_o,
   input  logic            instr_retire_i,
   output logic [XLEN-1:0] csr_mtvec_o,
   output logic [XLEN-1:0] csr_mepc_o,
   output logic [XLEN-1:0] csr_mstatus_o,
   output logic            glb_irqen_o,
   output logic            tmr_irqen_o,
   output logic            ext_irqen_o
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   // MPP is hard-wired to machine mode; only MIE/MPIE are storage bits
   localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'('h1800);
   localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'('h88);
   localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'('h888);
   localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'('h3);
   localparam logic [XLEN-1:0] MEPC_WMASK    = ~XLEN'('h1);

   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mie_q, mie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mcycle_q, mcycle_d;
   logic [XLEN-1:0] minstret_q, minstret_d;

   logic            wr_we   [2];
   logic [11:0]     wr_addr [2];
   logic [XLEN-1:0] wr_data [2];

   // Port 1 (clint) is applied after port 0 (ex), so it wins on a same-CSR collision
   always_comb begin
      wr_we[0]   = ex_csr_we_i;
      wr_addr[0] = ex_csr_waddr_i;
      wr_data[0] = ex_csr_wdata_i;
      wr_we[1]   = clint_we_i;
      wr_addr[1] = clint_addr_i;
      wr_data[1] = clint_wdata_i;
   end

   // Next-state: counters advance by default, writes override, unmapped/mhartid writes drop
   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mcycle_d   = mcycle_q + XLEN'(1);
      minstret_d = minstret_q + {{(XLEN-1){1'b0}}, instr_retire_i};
      for (int p = 0; p < 2; p++) begin
         if (wr_we[p]) begin
            case (wr_addr[p])
               A_MSTATUS:  mstatus_d  = MSTATUS_FIXED | (wr_data[p] & MSTATUS_WMASK);
               A_MIE:      mie_d      = wr_data[p] & MIE_WMASK;
               A_MTVEC:    mtvec_d    = wr_data[p] & MTVEC_WMASK;
               A_MSCRATCH: mscratch_d = wr_data[p];
               A_MEPC:     mepc_d     = wr_data[p] & MEPC_WMASK;
               A_MCAUSE:   mcause_d   = wr_data[p];
               A_MCYCLE:   mcycle_d   = wr_data[p];
               A_MINSTRET: minstret_d = wr_data[p];
               default:    ;
            endcase
         end
      end
   end

   // CSR state registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_q  <= MSTATUS_FIXED;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   // Execute-port read mux; current contents only, no write bypass
   always_comb begin
      ex_csr_rdata_o = '0;
      case (ex_csr_raddr_i)
         A_MSTATUS:  ex_csr_rdata_o = mstatus_q;
         A_MIE:      ex_csr_rdata_o = mie_q;
         A_MTVEC:    ex_csr_rdata_o = mtvec_q;
         A_MSCRATCH: ex_csr_rdata_o = mscratch_q;
         A_MEPC:     ex_csr_rdata_o = mepc_q;
         A_MCAUSE:   ex_csr_rdata_o = mcause_q;
         A_MCYCLE:   ex_csr_rdata_o = mcycle_q;
         A_MINSTRET: ex_csr_rdata_o = minstret_q;
         A_MHARTID:  ex_csr_rdata_o = '0;
         default:    ex_csr_rdata_o = '0;
      endcase
   end

   // Interrupt-controller read mux on the shared read/write address
   always_comb begin
      clint_rdata_o = '0;
      case (clint_addr_i)
         A_MSTATUS:  clint_rdata_o = mstatus_q;
         A_MIE:      clint_rdata_o = mie_q;
         A_MTVEC:    clint_rdata_o = mtvec_q;
         A_MSCRATCH: clint_rdata_o = mscratch_q;
         A_MEPC:     clint_rdata_o = mepc_q;
         A_MCAUSE:   clint_rdata_o = mcause_q;
         A_MCYCLE:   clint_rdata_o = mcycle_q;
         A_MINSTRET: clint_rdata_o = minstret_q;
         A_MHARTID:  clint_rdata_o = '0;
         default:    clint_rdata_o = '0;
      endcase
   end

   // Live register views and interrupt enables
   always_comb begin
      csr_mtvec_o   = mtvec_q;
      csr_mepc_o    = mepc_q;
      csr_mstatus_o = mstatus_q;
      glb_irqen_o   = mstatus_q[3];
      tmr_irqen_o   = mie_q[7];
      ext_irqen_o   = mie_q[11];
   end

endmodule

// File: tb/tb_csr_reg.sv
// tb/tb_csr_reg.sv - directed bench for csr_reg
module tb_csr_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_csr_we_i;
   logic [11:0] ex_csr_waddr_i;
   logic [63:0] ex_csr_wdata_i;
   logic [11:0] ex_csr_raddr_i;
   logic [63:0] ex_csr_rdata_o;
   logic        clint_we_i;
   logic [11:0] clint_addr_i;
   logic [63:0] clint_wdata_i;
   logic [63:0] clint_rdata_o;
   logic        instr_retire_i;
   logic [63:0] csr_mtvec_o;
   logic [63:0] csr_mepc_o;
   logic [63:0] csr_mstatus_o;
   logic        glb_irqen_o;
   logic        tmr_irqen_o;
   logic        ext_irqen_o;

   int n_cmp  = 0;
   int n_fail = 0;

   csr_reg #(.XLEN(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_csr_we_i    (ex_csr_we_i),
      .ex_csr_waddr_i (ex_csr_waddr_i),
      .ex_csr_wdata_i (ex_csr_wdata_i),
      .ex_csr_raddr_i (ex_csr_raddr_i),
      .ex_csr_rdata_o (ex_csr_rdata_o),
      .clint_we_i     (clint_we_i),
      .clint_addr_i   (clint_addr_i),
      .clint_wdata_i  (clint_wdata_i),
      .clint_rdata_o  (clint_rdata_o),
      .instr_retire_i (instr_retire_i),
      .csr_mtvec_o    (csr_mtvec_o),
      .csr_mepc_o     (csr_mepc_o),
      .csr_mstatus_o  (csr_mstatus_o),
      .glb_irqen_o    (glb_irqen_o),
      .tmr_irqen_o    (tmr_irqen_o),
      .ext_irqen_o    (ext_irqen_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Advance one full cycle; inputs change and outputs are sampled at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      ex_csr_we_i    = 1'b0;
      ex_csr_waddr_i = 12'h000;
      ex_csr_wdata_i = 64'h0;
      clint_we_i     = 1'b0;
      clint_wdata_i  = 64'h0;
      instr_retire_i = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b1;
      idle();
      ex_csr_raddr_i = 12'h300;
      clint_addr_i   = 12'hB00;

      // Reset applied with no clock edge yet
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mstatus_rd", ex_csr_rdata_o, 64'h1800);
      chk("rst_mcycle_rd", clint_rdata_o, 64'h0);
      chk("rst_mstatus_o", csr_mstatus_o, 64'h1800);
      chk("rst_irqen", {61'h0, glb_irqen_o, tmr_irqen_o, ext_irqen_o}, 64'h0);

      // First edge after release counts mcycle to 1
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("mcycle_first", clint_rdata_o, 64'h1);

      // mstatus write mask
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'h300;
      ex_csr_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 chk("mstatus_old", ex_csr_rdata_o, 64'h1800);
      step();
      idle();
      chk("mstatus_mask", ex_csr_rdata_o, 64'h1888);
      chk("glb_irqen", {63'h0, glb_irqen_o}, 64'h1);

      // mie write mask through the clint port
      clint_we_i    = 1'b1;
      clint_addr_i  = 12'h304;
      clint_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      idle();
      chk("mie_mask", clint_rdata_o, 64'h888);
      chk("tmr_ext_irqen", {62'h0, tmr_irqen_o, ext_irqen_o}, 64'h3);

      // Same-CSR collision: clint wins
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'h341;
      ex_csr_wdata_i = 64'h100;
      clint_we_i     = 1'b1;
      clint_addr_i   = 12'h341;
      clint_wdata_i  = 64'h8000_0004;
      step();
      idle();
      chk("collision_mepc", csr_mepc_o, 64'h8000_0004);

      // mepc bit 0 forced low
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'h341;
      ex_csr_wdata_i = 64'h3;
      step();
      idle();
      chk("mepc_bit0", csr_mepc_o, 64'h2);

      // Dual write to different CSRs
      clint_we_i     = 1'b1;
      clint_addr_i   = 12'h342;
      clint_wdata_i  = 64'h8000_0000_0000_0007;
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'h305;
      ex_csr_wdata_i = 64'h8000_0103;
      step();
      idle();
      chk("dual_mcause", clint_rdata_o, 64'h8000_0000_0000_0007);
      chk("dual_mtvec", csr_mtvec_o, 64'h8000_0100);

      // No write-to-read bypass on mscratch
      ex_csr_raddr_i = 12'h340;
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'h340;
      ex_csr_wdata_i = 64'h5A;
      #1 chk("nobypass_old", ex_csr_rdata_o, 64'h0);
      step();
      idle();
      chk("nobypass_new", ex_csr_rdata_o, 64'h5A);

      // mcycle load then wrap
      clint_we_i    = 1'b1;
      clint_addr_i  = 12'hB00;
      clint_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      idle();
      chk("mcycle_load", clint_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      chk("mcycle_wrap", clint_rdata_o, 64'h0);
      step();
      chk("mcycle_after_wrap", clint_rdata_o, 64'h1);

      // minstret counts three retire pulses
      clint_addr_i = 12'hB02;
      for (int i = 0; i < 3; i++) begin
         instr_retire_i = 1'b1;
         step();
         instr_retire_i = 1'b0;
         step();
      end
      chk("minstret_three", clint_rdata_o, 64'h3);

      // Write beats a simultaneous retire
      instr_retire_i = 1'b1;
      clint_we_i     = 1'b1;
      clint_wdata_i  = 64'h10;
      step();
      idle();
      chk("minstret_wr_prio", clint_rdata_o, 64'h10);

      // Unmapped and mhartid writes ignored, reads are zero
      clint_we_i     = 1'b1;
      clint_addr_i   = 12'h7FF;
      clint_wdata_i  = 64'hDEAD;
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'hF14;
      ex_csr_wdata_i = 64'hBEEF;
      ex_csr_raddr_i = 12'hF14;
      step();
      idle();
      chk("unmapped_rd", clint_rdata_o, 64'h0);
      chk("mhartid_rd", ex_csr_rdata_o, 64'h0);
      ex_csr_raddr_i = 12'h340;
      #1 chk("mscratch_kept", ex_csr_rdata_o, 64'h5A);

      // Mid-stream reset with a pending write: immediate, no edge needed
      @(negedge clk);
      ex_csr_we_i    = 1'b1;
      ex_csr_waddr_i = 12'h340;
      ex_csr_wdata_i = 64'hFF;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_mscratch", ex_csr_rdata_o, 64'h0);
      chk("mid_rst_mstatus", csr_mstatus_o, 64'h1800);
      chk("mid_rst_mepc", csr_mepc_o, 64'h0);
      chk("mid_rst_irqen", {61'h0, glb_irqen_o, tmr_irqen_o, ext_irqen_o}, 64'h0);
      step();
      chk("held_rst_mscratch", ex_csr_rdata_o, 64'h0);
      clint_addr_i = 12'hB00;
      #1 chk("held_rst_mcycle", clint_rdata_o, 64'h0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      step();
      chk("post_rst_mcycle", clint_rdata_o, 64'h1);
      clint_addr_i = 12'h7FF;
      ex_csr_raddr_i = 12'hF14;
      #1;
      chk("post_rst_7ff", clint_rdata_o, 64'h0);
      chk("post_rst_f14", ex_csr_rdata_o, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
